// File: rtl/sb_config_loader.sv
// Serial configuration loader for a row of switch box elements.
// Shifts a TOT-bit frame LSB-first, checks even parity, then commits it atomically to cfg_out.
module sb_config_loader #(
    parameter int unsigned N_ELEM = 2,
    parameter int unsigned CFG_W  = 12,
    parameter int unsigned TOT    = N_ELEM * CFG_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_start,
    input  logic           cfg_bit,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    output logic [TOT-1:0] cfg_out,
    output logic           cfg_done,
    output logic           cfg_err,
    output logic           busy
);

    localparam int unsigned CntW = (TOT > 1) ? $clog2(TOT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TOT - 1);

    typedef enum logic [1:0] {StIdle, StShift, StParity, StError} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            par_q, par_d;
    logic [TOT-1:0]  shadow_q, shadow_d;
    logic [TOT-1:0]  out_q, out_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        shadow_d  = shadow_q;
        out_d     = out_q;
        done_d    = 1'b0;
        err_d     = err_q;
        busy      = (state_q == StShift) || (state_q == StParity);
        cfg_ready = busy && !cfg_start;
        accept    = cfg_valid && cfg_ready;

        if (cfg_start) begin
            // Restart drops any concurrent beat; shadow is fully overwritten by the new frame.
            state_d = StShift;
            cnt_d   = '0;
            par_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StShift: begin
                    if (accept) begin
                        shadow_d = {cfg_bit, shadow_q[TOT-1:1]};
                        par_d    = par_q ^ cfg_bit;
                        if (cnt_q == CntLast) begin
                            state_d = StParity;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                StParity: begin
                    if (accept) begin
                        if (cfg_bit == par_q) begin
                            out_d   = shadow_q;
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StError;
                        end
                    end
                end
                StIdle, StError: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            shadow_q <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cfg_out  = out_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed self-checking bench for sb_config_loader with N_ELEM=2, CFG_W=12 (24-bit frames).
module tb_sb_config_loader;

    localparam int unsigned TOT = 24;

    logic           clk;
    logic           rst_n;
    logic           cfg_start;
    logic           cfg_bit;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [TOT-1:0] cfg_out;
    logic           cfg_done;
    logic           cfg_err;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    sb_config_loader #(
        .N_ELEM(2),
        .CFG_W (12)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_start(cfg_start),
        .cfg_bit  (cfg_bit),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_out  (cfg_out),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic cycle(input logic s, input logic v, input logic b);
        cfg_start = s;
        cfg_valid = v;
        cfg_bit   = b;
        @(posedge clk);
        #1;
        if (cfg_done === 1'b1) done_seen++;
    endtask

    task automatic send_bits(input logic [TOT-1:0] d, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, ~d[i]);
            cycle(1'b0, 1'b1, d[i]);
        end
    endtask

    initial begin
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        check("rst_out",   32'(cfg_out), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h0);
        check("rst_done",  32'(cfg_done), 32'h0);
        check("rst_err",   32'(cfg_err), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        #1 rst_n = 1'b1;

        // Idle ignores beats
        cycle(1'b0, 1'b1, 1'b1);
        check("idle_ready", 32'(cfg_ready), 32'h0);
        check("idle_busy",  32'(busy), 32'h0);

        // Good frame 24'h123ABC, parity 1
        done_seen = 0;
        cycle(1'b1, 1'b0, 1'b0);
        check("good_busy", 32'(busy), 32'h1);
        send_bits(24'h123ABC, TOT, 1'b0);
        check("good_in_parity", 32'(busy), 32'h1);
        check("good_no_partial", 32'(cfg_out), 32'h0);
        cycle(1'b0, 1'b1, 1'b1);
        check("good_done", 32'(cfg_done), 32'h1);
        check("good_out",  32'(cfg_out), 32'h123ABC);
        check("good_err",  32'(cfg_err), 32'h0);
        check("good_idle", 32'(busy), 32'h0);
        cycle(1'b0, 1'b0, 1'b0);
        check("good_done_1cyc", 32'(cfg_done), 32'h0);
        check("good_done_cnt", 32'(done_seen), 32'h1);

        // Bad parity: same data, parity 0
        done_seen = 0;
        cycle(1'b1, 1'b0, 1'b0);
        send_bits(24'h123ABC, TOT, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("bad_err",  32'(cfg_err), 32'h1);
        check("bad_done", 32'(cfg_done), 32'h0);
        check("bad_out",  32'(cfg_out), 32'h123ABC);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        check("bad_ready", 32'(cfg_ready), 32'h0);
        check("bad_busy",  32'(busy), 32'h0);
        check("bad_err_sticky", 32'(cfg_err), 32'h1);
        check("bad_done_cnt", 32'(done_seen), 32'h0);

        // Restart after 10 bits with a concurrent beat, then 24'hFFF000 parity 0
        done_seen = 0;
        cycle(1'b1, 1'b0, 1'b0);
        check("rs_err_clr", 32'(cfg_err), 32'h0);
        send_bits(24'h123ABC, 10, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        send_bits(24'hFFF000, TOT, 1'b0);
        check("rs_no_partial", 32'(cfg_out), 32'h123ABC);
        cycle(1'b0, 1'b1, 1'b0);
        check("rs_done", 32'(cfg_done), 32'h1);
        check("rs_out",  32'(cfg_out), 32'hFFF000);
        check("rs_err",  32'(cfg_err), 32'h0);

        // Valid gaps with wrong bits during gaps
        done_seen = 0;
        cycle(1'b1, 1'b0, 1'b0);
        send_bits(24'h123ABC, TOT, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("gap_hold", 32'(cfg_out), 32'hFFF000);
        check("gap_wait_parity", 32'(busy), 32'h1);
        cycle(1'b0, 1'b1, 1'b1);
        check("gap_done", 32'(cfg_done), 32'h1);
        check("gap_out",  32'(cfg_out), 32'h123ABC);
        cycle(1'b0, 1'b0, 1'b0);
        check("gap_done_cnt", 32'(done_seen), 32'h1);

        // Mid-frame reset after 15 bits
        done_seen = 0;
        cycle(1'b1, 1'b0, 1'b0);
        send_bits(24'hFFF000, 15, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_out",   32'(cfg_out), 32'h0);
        check("mrst_busy",  32'(busy), 32'h0);
        check("mrst_ready", 32'(cfg_ready), 32'h0);
        check("mrst_err",   32'(cfg_err), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1);
        check("mrst_idle",  32'(busy), 32'h0);
        check("mrst_out_hold", 32'(cfg_out), 32'h0);
        check("mrst_no_done", 32'(done_seen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sb_config_loader.md
SB_CONFIG_LOADER -- requirements
Module: sb_config_loader

Interface
REQ-001 The block SHALL have parameter N_ELEM, default 2, meaning the number of switch box elements configured by one frame.
REQ-002 The block SHALL have parameter CFG_W, default 12, meaning the config bits per element; TOT = N_ELEM*CFG_W.
REQ-003 The block SHALL have port clk  input  1  as its single clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  as its asynchronous, active-low reset.
REQ-005 The block SHALL have port cfg_start  input  1  to begin, or restart, a frame.
REQ-006 The block SHALL have port cfg_bit  input  1  carrying serial config data, LSB first.
REQ-007 The block SHALL have port cfg_valid  input  1  to qualify cfg_bit.
REQ-008 The block SHALL have port cfg_ready  output  1  to signal that the loader accepts a bit this cycle.
REQ-009 The block SHALL have port cfg_out  output  TOT  carrying the active config; element k SHALL use cfg_out[CFG_W*k+CFG_W-1 : CFG_W*k] as its c[11:0].
REQ-010 The block SHALL have port cfg_done  output  1  as a one-cycle commit pulse.
REQ-011 The block SHALL have port cfg_err  output  1  as a sticky parity-error flag.
REQ-012 The block SHALL have port busy  output  1  asserted when state is SHIFT or PARITY.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT, PARITY and ERROR.
REQ-014 A beat SHALL be accepted exactly when cfg_valid && cfg_ready.
REQ-015 cfg_ready SHALL equal (state==SHIFT || state==PARITY) && !cfg_start, combinationally.
REQ-016 In any state, cfg_start=1 SHALL move the block to SHIFT with bit counter=0, parity accumulator=0 and cfg_err=0.
REQ-017 In the case of REQ-016, the block SHALL leave shadow and cfg_out unchanged and SHALL drop any concurrent beat.
REQ-018 In SHIFT, each accepted beat SHALL update shadow <= {cfg_bit, shadow[TOT-1:1]}, so that the first bit received lands in bit 0 after TOT beats.
REQ-019 In SHIFT, each accepted beat SHALL also increment the counter and XOR cfg_bit into the parity accumulator.
REQ-020 The accepted beat taken while counter==TOT-1 SHALL move the block to PARITY.
REQ-021 The counter SHALL be $clog2(TOT) bits wide and SHALL never wrap within a frame.
REQ-022 Cycles without an accepted beat SHALL hold shadow, counter and parity unchanged, so that valid gaps have no effect.
REQ-023 In PARITY, an accepted beat SHALL be the even-parity bit, which must equal the XOR of the TOT data bits.
REQ-024 On a parity match, at that clock edge the block SHALL load cfg_out <= shadow, set cfg_done=1 for exactly one cycle and go to IDLE.
REQ-025 On a parity mismatch, the block SHALL go to ERROR with cfg_err=1, leaving cfg_out unchanged, and SHALL NOT pulse cfg_done.
REQ-026 ERROR SHALL hold cfg_err=1 and cfg_ready=0 until cfg_start or reset.
REQ-027 IDLE SHALL hold all state, with cfg_ready=0 and cfg_bit ignored.
REQ-028 cfg_out SHALL change only on a parity-match commit or on reset, so that partial frames are never visible to the switch boxes.
REQ-029 cfg_out, cfg_done and cfg_err SHALL be registered outputs; cfg_ready and busy SHALL be decoded from state (plus cfg_start for cfg_ready).

Reset
REQ-030 rst_n=0 SHALL act immediately, independent of clk.
REQ-031 On reset, the block SHALL enter IDLE and clear counter, parity and shadow to 0.
REQ-032 On reset, cfg_out SHALL be 0, which opens all switches and avoids bus contention; cfg_done, cfg_err, cfg_ready and busy SHALL all be 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame and clear cfg_out to 0.
REQ-034 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification (N_ELEM=2, TOT=24)
REQ-035 Reset check: assert rst_n=0 with no clock edge -> cfg_out=0, ready/done/err/busy all 0.
REQ-036 Good frame: cfg_start, then 24'h123ABC LSB-first, then parity bit 1 -> cfg_out=24'h123ABC, cfg_done high for exactly one cycle, cfg_err=0.
REQ-037 Bad parity: same data with parity bit 0 -> cfg_err=1, cfg_out keeps its prior value, no cfg_done, cfg_ready=0 until the next cfg_start.
REQ-038 Valid gaps: the good frame sent with random cfg_valid deassertion -> identical result to REQ-036, bits sent while cfg_valid=0 ignored.
REQ-039 Restart: cfg_start after 10 bits, asserted together with a valid beat, then a full frame 24'hFFF000 with parity 0 -> cfg_out=24'hFFF000, and the dropped beat has no effect.
REQ-040 Mid-frame reset: rst_n pulsed low after 15 bits of a frame following a committed config -> cfg_out=0, state IDLE, no cfg_done.
